// File: rtl/canvas_rect_scheduler.sv
// Round-robin arbiter feeding one canvas write port: each grant rasterises a
// clamped, corner-normalised filled rectangle at one pixel per clock.
module canvas_rect_scheduler #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int NUM_REQ     = 2,
    parameter int COLOR_WIDTH = 3,
    parameter logic [COLOR_WIDTH-1:0] COLOR_NONE = '0,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ-1:0][XW-1:0]            req_x0,
    input  logic [NUM_REQ-1:0][XW-1:0]            req_x1,
    input  logic [NUM_REQ-1:0][YW-1:0]            req_y0,
    input  logic [NUM_REQ-1:0][YW-1:0]            req_y1,
    input  logic [NUM_REQ-1:0][COLOR_WIDTH-1:0]   req_color,
    output logic [NUM_REQ-1:0]                    ack,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  draw_enable,
    output logic [XW-1:0]                         draw_x,
    output logic [YW-1:0]                         draw_y,
    output logic [COLOR_WIDTH-1:0]                draw_color
);

    localparam int          PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NR   = NUM_REQ;
    localparam logic [XW-1:0] XLIM = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YLIM = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            rr_q, rr_d;
    logic [XW-1:0]            xmin_q, xmax_q, xmin_d, xmax_d;
    logic [YW-1:0]            ymin_q, ymax_q, ymin_d, ymax_d;
    logic [NUM_REQ-1:0]       ack_d;
    logic                     busy_d, done_d, en_d;
    logic [XW-1:0]            x_d;
    logic [YW-1:0]            y_d;
    logic [COLOR_WIDTH-1:0]   color_d;

    logic                     found;
    logic [PW-1:0]            gnt, cand;
    logic [XW-1:0]            gx0, gx1, gxmin, gxmax;
    logic [YW-1:0]            gy0, gy1, gymin, gymax;

    // First pending requester at or after the round-robin pointer, wrapping.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            cand = PW'((32'(rr_q) + i) % NR);
            if (!found && req[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    always_comb begin
        gx0   = req_x0[gnt];
        gx1   = req_x1[gnt];
        gy0   = req_y0[gnt];
        gy1   = req_y1[gnt];
        gxmin = (gx0 < gx1) ? gx0 : gx1;
        gxmax = (gx0 < gx1) ? gx1 : gx0;
        gymin = (gy0 < gy1) ? gy0 : gy1;
        gymax = (gy0 < gy1) ? gy1 : gy0;
        if (gxmin > XLIM) gxmin = XLIM;
        if (gxmax > XLIM) gxmax = XLIM;
        if (gymin > YLIM) gymin = YLIM;
        if (gymax > YLIM) gymax = YLIM;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        ack_d   = '0;
        done_d  = 1'b0;
        en_d    = 1'b0;
        x_d     = draw_x;
        y_d     = draw_y;
        color_d = draw_color;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = DRAW;
                    ack_d[gnt] = 1'b1;
                    rr_d       = PW'((32'(gnt) + 32'd1) % NR);
                    xmin_d     = gxmin;
                    xmax_d     = gxmax;
                    ymin_d     = gymin;
                    ymax_d     = gymax;
                    x_d        = gxmin;
                    y_d        = gymin;
                    color_d    = req_color[gnt];
                    en_d       = 1'b1;
                end
            end
            DRAW: begin
                if (draw_x == xmax_q && draw_y == ymax_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (draw_x == xmax_q) begin
                    x_d  = xmin_q;
                    y_d  = draw_y + 1'b1;
                    en_d = 1'b1;
                end else begin
                    x_d  = draw_x + 1'b1;
                    en_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
            ack         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            draw_enable <= 1'b0;
            draw_x      <= '0;
            draw_y      <= '0;
            draw_color  <= COLOR_NONE;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            ack         <= ack_d;
            busy        <= busy_d;
            done        <= done_d;
            draw_enable <= en_d;
            draw_x      <= x_d;
            draw_y      <= y_d;
            draw_color  <= color_d;
        end
    end

endmodule

// File: tb/tb_canvas_rect_scheduler.sv
// Bench for canvas_rect_scheduler: queue-based expectation model checked every
// cycle, plus directed rectangles with literal pixel lists.
module tb_canvas_rect_scheduler;

    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] BLUE = 3'd1;
    localparam logic [2:0] RED  = 3'd4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      req;
    logic [1:0][2:0] req_x0, req_x1, req_y0, req_y1, req_color;
    logic [1:0]      ack;
    logic            busy, done, draw_enable;
    logic [2:0]      draw_x, draw_y, draw_color;

    logic [1:0]      req6;
    logic [1:0][2:0] x06, x16, y06, y16, c6;
    logic [1:0]      ack6;
    logic            busy6, done6, en6;
    logic [2:0]      dx6, dy6, dc6;

    canvas_rect_scheduler #(.WIDTH(8), .HEIGHT(8), .NUM_REQ(2), .COLOR_WIDTH(3), .COLOR_NONE(3'd0)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1), .req_color(req_color),
        .ack(ack), .busy(busy), .done(done), .draw_enable(draw_enable),
        .draw_x(draw_x), .draw_y(draw_y), .draw_color(draw_color)
    );

    canvas_rect_scheduler #(.WIDTH(6), .HEIGHT(6), .NUM_REQ(2), .COLOR_WIDTH(3), .COLOR_NONE(3'd0)) dut6 (
        .clk(clk), .reset_n(reset_n), .req(req6),
        .req_x0(x06), .req_x1(x16), .req_y0(y06), .req_y1(y16), .req_color(c6),
        .ack(ack6), .busy(busy6), .done(done6), .draw_enable(en6),
        .draw_x(dx6), .draw_y(dy6), .draw_color(dc6)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: a grant expands into a queue of per-cycle expected outputs
    // {ack, busy, done, en, x, y, color}: pixels, one done cycle, one idle cycle.
    typedef logic [13:0] rec_t;
    rec_t       expq[$];
    int         rr_m = 0;
    logic [2:0] hx = 3'd0, hy = 3'd0, hc = NONE;

    function automatic rec_t mk(input logic [1:0] a, input logic b, input logic d, input logic e,
                                input logic [2:0] x, input logic [2:0] y, input logic [2:0] c);
        return {a, b, d, e, x, y, c};
    endfunction

    task automatic plan(input logic [1:0] rq);
        int g, xa, xb, ya, yb, t;
        logic [2:0] c;
        bit first;
        g = -1;
        for (int k = 0; k < 2; k++) begin
            t = (rr_m + k) % 2;
            if (g < 0 && rq[t]) g = t;
        end
        rr_m = (g + 1) % 2;
        xa = int'(req_x0[g]); xb = int'(req_x1[g]);
        ya = int'(req_y0[g]); yb = int'(req_y1[g]);
        if (xa > xb) begin t = xa; xa = xb; xb = t; end
        if (ya > yb) begin t = ya; ya = yb; yb = t; end
        if (xb > 7) xb = 7;
        if (ya > 7) ya = 7;
        c = req_color[g];
        first = 1'b1;
        for (int y = ya; y <= yb; y++)
            for (int x = xa; x <= xb; x++) begin
                expq.push_back(mk(first ? (2'b01 << g) : 2'b00, 1'b1, 1'b0, 1'b1, 3'(x), 3'(y), c));
                first = 1'b0;
            end
        hx = 3'(xb); hy = 3'(yb); hc = c;
        expq.push_back(mk(2'b00, 1'b1, 1'b1, 1'b0, hx, hy, hc));
        expq.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, hx, hy, hc));
    endtask

    always @(posedge clk or negedge reset_n) begin : model
        rec_t e;
        if (!reset_n) begin
            expq.delete();
            rr_m = 0; hx = 3'd0; hy = 3'd0; hc = NONE;
            e = mk(2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, NONE);
        end else begin
            if (expq.size() == 0 && req != 2'b00) plan(req);
            if (expq.size() > 0) e = expq.pop_front();
            else e = mk(2'b00, 1'b0, 1'b0, 1'b0, hx, hy, hc);
        end
        #1;
        chk($sformatf("cycle@%0t", $time),
            {18'b0, ack, busy, done, draw_enable, draw_x, draw_y, draw_color}, {18'b0, e});
    end

    logic [8:0] wlog[$];
    logic [2:0] canvas[8][8];
    int         cyc = 0;
    int         acklog_c[$];
    logic [1:0] acklog_v[$];

    always @(posedge clk) begin
        cyc++;
        #1;
        if (reset_n && draw_enable) begin
            wlog.push_back({draw_x, draw_y, draw_color});
            canvas[draw_y][draw_x] = draw_color;
        end
        if (ack != 2'b00) begin
            acklog_c.push_back(cyc);
            acklog_v.push_back(ack);
        end
    end

    task automatic wait_ack(input int i);
        int n;
        n = 0;
        while (!ack[i] && n < 30) begin @(negedge clk); n++; end
        chk($sformatf("ack%0d_seen", i), {31'b0, ack[i]}, 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    logic [8:0] exp2[4];
    logic [8:0] w6[$];
    int base, b;

    initial begin
        exp2 = '{{3'd1, 3'd2, BLUE}, {3'd2, 3'd2, BLUE}, {3'd1, 3'd3, BLUE}, {3'd2, 3'd3, BLUE}};
        req = '0; req_x0 = '0; req_x1 = '0; req_y0 = '0; req_y1 = '0; req_color = '0;
        req6 = '0; x06 = '0; x16 = '0; y06 = '0; y16 = '0; c6 = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Normal-order corners
        req_x0[0] = 3'd1; req_y0[0] = 3'd2; req_x1[0] = 3'd2; req_y1[0] = 3'd3; req_color[0] = BLUE;
        base = wlog.size();
        req[0] = 1'b1;
        wait_ack(0);
        req[0] = 1'b0;
        wait_done();
        chk("t2_count", 32'(wlog.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) chk($sformatf("t2_px%0d", k), {23'b0, wlog[base + k]}, {23'b0, exp2[k]});
        chk("t2_canvas12", {29'b0, canvas[2][1]}, {29'b0, BLUE});
        chk("t2_canvas23", {29'b0, canvas[3][2]}, {29'b0, BLUE});
        @(negedge clk);
        chk("t2_done_pulse", {31'b0, done}, 32'd0);

        // Swapped corners
        req_x0[0] = 3'd2; req_y0[0] = 3'd3; req_x1[0] = 3'd1; req_y1[0] = 3'd2;
        base = wlog.size();
        req[0] = 1'b1;
        wait_ack(0);
        req[0] = 1'b0;
        wait_done();
        chk("t3_count", 32'(wlog.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) chk($sformatf("t3_px%0d", k), {23'b0, wlog[base + k]}, {23'b0, exp2[k]});
        repeat (2) @(negedge clk);

        // Async reset with no clock edge
        #2 reset_n = 1'b0;
        #1;
        chk("t1_outs", {20'b0, ack, busy, done, draw_enable, draw_x, draw_y},
            {20'b0, 2'b00, 3'b000, 3'd0, 3'd0});
        chk("t1_color", {29'b0, draw_color}, {29'b0, NONE});
        @(negedge clk);
        reset_n = 1'b1;

        // Continuous contention, 1x1 rectangles
        req_x0[0] = 3'd0; req_x1[0] = 3'd0; req_y0[0] = 3'd0; req_y1[0] = 3'd0; req_color[0] = BLUE;
        req_x0[1] = 3'd7; req_x1[1] = 3'd7; req_y0[1] = 3'd7; req_y1[1] = 3'd7; req_color[1] = RED;
        b = acklog_c.size();
        req = 2'b11;
        for (int n = 0; n < 40 && acklog_c.size() < b + 4; n++) @(negedge clk);
        req = 2'b00;
        chk("t4_nacks", 32'(acklog_c.size() >= b + 4), 32'd1);
        if (acklog_c.size() >= b + 4) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("t4_gnt%0d", k), {30'b0, acklog_v[b + k]}, (k % 2 == 1) ? 32'd2 : 32'd1);
            for (int k = 1; k < 4; k++)
                chk($sformatf("t4_gap%0d", k), 32'(acklog_c[b + k] - acklog_c[b + k - 1]), 32'd3);
        end
        repeat (4) @(negedge clk);

        // Full fill aborted by reset after two writes
        req_x0[0] = 3'd0; req_y0[0] = 3'd0; req_x1[0] = 3'd7; req_y1[0] = 3'd7;
        base = wlog.size();
        req[0] = 1'b1;
        for (int n = 0; n < 30 && wlog.size() < base + 2; n++) @(negedge clk);
        #2 reset_n = 1'b0;
        req = 2'b00;
        #1;
        chk("t6_en_low", {30'b0, draw_enable, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_no_resume", 32'(wlog.size() - base), 32'd2);
        req_x0[1] = 3'd5; req_y0[1] = 3'd5; req_x1[1] = 3'd3; req_y1[1] = 3'd4; req_color[1] = RED;
        req[1] = 1'b1;
        wait_ack(1);
        req[1] = 1'b0;
        wait_done();
        chk("t6_count", 32'(wlog.size() - base), 32'd8);
        chk("t6_first", {23'b0, wlog[base + 2]}, {23'b0, 3'd3, 3'd4, RED});
        chk("t6_last", {23'b0, wlog[base + 7]}, {23'b0, 3'd5, 3'd5, RED});
        repeat (2) @(negedge clk);

        // 6x6 canvas clamping
        x06[0] = 3'd4; y06[0] = 3'd4; x16[0] = 3'd7; y16[0] = 3'd7; c6[0] = RED;
        req6[0] = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (en6) w6.push_back({dx6, dy6, dc6});
            if (ack6[0]) req6[0] = 1'b0;
            if (done6) break;
        end
        chk("t5_count", 32'(w6.size()), 32'd4);
        chk("t5_px0", {23'b0, w6[0]}, {23'b0, 3'd4, 3'd4, RED});
        chk("t5_px1", {23'b0, w6[1]}, {23'b0, 3'd5, 3'd4, RED});
        chk("t5_px2", {23'b0, w6[2]}, {23'b0, 3'd4, 3'd5, RED});
        chk("t5_px3", {23'b0, w6[3]}, {23'b0, 3'd5, 3'd5, RED});

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
